// File: rtl/dpram_s2_arbiter_if.sv
// Requester-side bus of the s2 arbiter: per-requester command fields plus the shared read return.
interface dpram_s2_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 2
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        wr;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ*32-1:0]     wdata;
  logic [NUM_REQ*4-1:0]      be;
  logic [NUM_REQ-1:0]        ack;
  logic [NUM_REQ-1:0]        rd_valid;
  logic [31:0]               rd_data;

  modport master (output req, wr, addr, wdata, be, input ack, rd_valid, rd_data);
  modport slave  (input req, wr, addr, wdata, be, output ack, rd_valid, rd_data);
endinterface

// File: rtl/dpram_s2_arbiter.sv
// Round-robin arbiter/sequencer for port s2 of the HPS-shared dual-port RAM.
// Zero-fills the RAM after every reset, then serves NUM_REQ fabric requesters with tagged read return.
module dpram_s2_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int ADDR_W       = 2,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  dpram_s2_arbiter_if.slave bus,
  output logic              init_done,
  output logic [ADDR_W-1:0] dualport_ram_s2_address,
  output logic              dualport_ram_s2_chipselect,
  output logic              dualport_ram_s2_clken,
  output logic              dualport_ram_s2_write,
  output logic [31:0]       dualport_ram_s2_writedata,
  output logic [3:0]        dualport_ram_s2_byteenable,
  input  logic [31:0]       dualport_ram_s2_readdata
);
  localparam int DATA_W = 32;
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W:0] FILL_END = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W:0]    fill_cnt_q, fill_d, fill_inc;
  logic [IDX_W-1:0]   ptr_q, ptr_d, win;
  logic [NUM_REQ-1:0] ack_q, ack_d, elig;
  logic               grant;
  logic               cmd_cs_d, cmd_wr_d;
  logic [ADDR_W-1:0]  cmd_addr_d;
  logic [DATA_W-1:0]  cmd_wdata_d;
  logic [3:0]         cmd_be_d;
  logic               tag_vld_d;
  logic               tag_vld_p [0:READ_LATENCY];
  logic [IDX_W-1:0]   tag_idx_p [0:READ_LATENCY];
  logic [NUM_REQ-1:0] rd_valid_q;
  logic [DATA_W-1:0]  rd_data_q;

  assign dualport_ram_s2_clken = ~reset_reset;
  assign fill_inc     = fill_cnt_q + (ADDR_W+1)'(1);
  assign bus.ack      = ack_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;

  // A requester acked this cycle is masked so its held request is not issued twice.
  always_comb begin
    elig  = bus.req & ~ack_q;
    grant = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant && elig[idx]) begin
        grant = 1'b1;
        win   = IDX_W'(idx);
      end
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) state_q <= S_INIT;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT: if (fill_inc == FILL_END) state_d = S_RUN;
      S_RUN:  state_d = S_RUN;
    endcase
  end

  always_comb begin
    cmd_cs_d    = 1'b0;
    cmd_wr_d    = 1'b0;
    cmd_addr_d  = dualport_ram_s2_address;
    cmd_wdata_d = dualport_ram_s2_writedata;
    cmd_be_d    = dualport_ram_s2_byteenable;
    ack_d       = '0;
    ptr_d       = ptr_q;
    fill_d      = fill_cnt_q;
    tag_vld_d   = 1'b0;
    case (state_q)
      S_INIT: begin
        cmd_cs_d    = 1'b1;
        cmd_wr_d    = 1'b1;
        cmd_addr_d  = fill_cnt_q[ADDR_W-1:0];
        cmd_wdata_d = '0;
        cmd_be_d    = 4'hF;
        fill_d      = fill_inc;
      end
      S_RUN: begin
        if (grant) begin
          cmd_cs_d    = 1'b1;
          cmd_wr_d    = bus.wr[win];
          cmd_addr_d  = bus.addr[int'(win)*ADDR_W +: ADDR_W];
          cmd_wdata_d = bus.wdata[int'(win)*DATA_W +: DATA_W];
          cmd_be_d    = bus.be[int'(win)*4 +: 4];
          ack_d[win]  = 1'b1;
          ptr_d       = (int'(win) == NUM_REQ-1) ? '0 : win + IDX_W'(1);
          tag_vld_d   = ~bus.wr[win];
        end
      end
    endcase
  end

  // p0: command stage, registered onto s2
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      dualport_ram_s2_chipselect <= 1'b0;
      dualport_ram_s2_write      <= 1'b0;
      dualport_ram_s2_address    <= '0;
      dualport_ram_s2_writedata  <= '0;
      dualport_ram_s2_byteenable <= '0;
      ack_q                      <= '0;
      ptr_q                      <= '0;
      fill_cnt_q                 <= '0;
      init_done                  <= 1'b0;
    end else begin
      dualport_ram_s2_chipselect <= cmd_cs_d;
      dualport_ram_s2_write      <= cmd_wr_d;
      dualport_ram_s2_address    <= cmd_addr_d;
      dualport_ram_s2_writedata  <= cmd_wdata_d;
      dualport_ram_s2_byteenable <= cmd_be_d;
      ack_q                      <= ack_d;
      ptr_q                      <= ptr_d;
      fill_cnt_q                 <= fill_d;
      init_done                  <= (state_q == S_RUN);
    end
  end

  // p1..pREAD_LATENCY: read tag follows the RAM latency
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      for (int s = 0; s <= READ_LATENCY; s++) begin
        tag_vld_p[s] <= 1'b0;
        tag_idx_p[s] <= '0;
      end
    end else begin
      tag_vld_p[0] <= tag_vld_d;
      tag_idx_p[0] <= win;
      for (int s = 1; s <= READ_LATENCY; s++) begin
        tag_vld_p[s] <= tag_vld_p[s-1];
        tag_idx_p[s] <= tag_idx_p[s-1];
      end
    end
  end

  // Return stage: rd_data holds its last value between reads
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      rd_valid_q <= '0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= '0;
      if (tag_vld_p[READ_LATENCY]) begin
        rd_valid_q[tag_idx_p[READ_LATENCY]] <= 1'b1;
        rd_data_q                           <= dualport_ram_s2_readdata;
      end
    end
  end
endmodule

// File: doc/dpram_s2_arbiter.md
Name: dpram_s2_arbiter

Overview:
- Round-robin arbiter and sequencer for port s2 of the HPS-shared dual-port RAM (dualport_ram_s2_*). The HPS owns port s1.
- Shares s2 between NUM_REQ fabric requesters with a registered command stage.
- Routes read data back to the requester that issued the read.
- After every reset it zero-fills the whole RAM before serving any requester.

Parameters:
- NUM_REQ, 2, number of fabric requesters (2..4).
- ADDR_W, 2, s2 word-address width; RAM depth is 2^ADDR_W words.
- READ_LATENCY, 1, s2 readdata latency in cycles after the command cycle (1 or 2).

Ports:
- clk_clk  in  1  single clock for all logic and s2 (dualport_ram_clk2_clk is tied to it).
- reset_reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester request; held with its fields stable until ack.
- wr  in  NUM_REQ  1 = write, 0 = read.
- addr  in  NUM_REQ*ADDR_W  word address; requester i occupies slice i.
- wdata  in  NUM_REQ*32  write data.
- be  in  NUM_REQ*4  byte enables.
- ack  out  NUM_REQ  one-cycle pulse: command accepted and issued.
- rd_valid  out  NUM_REQ  one-cycle pulse: rd_data belongs to requester i.
- rd_data  out  32  read data, shared by all requesters.
- init_done  out  1  1 once the zero-fill is complete.
- dualport_ram_s2_address  out  ADDR_W  s2 address.
- dualport_ram_s2_chipselect  out  1  s2 chipselect.
- dualport_ram_s2_clken  out  1  s2 clock enable.
- dualport_ram_s2_write  out  1  s2 write strobe.
- dualport_ram_s2_writedata  out  32  s2 write data.
- dualport_ram_s2_byteenable  out  4  s2 byte enables.
- dualport_ram_s2_readdata  in  32  s2 read data.

Behaviour:
- Reset values: ack=0, rd_valid=0, rd_data=0, init_done=0, s2 address/chipselect/write/writedata/byteenable = 0. clken is 1 whenever reset is deasserted. Round-robin pointer is set so requester 0 has top priority.
- FSM states:
  - INIT: entered on reset. Issues writes of writedata=0, byteenable=4'hF to addresses 0..2^ADDR_W-1, one per cycle (chipselect=1, write=1). After the write to the last address, goes to RUN.
  - RUN: init_done=1, registered, from the first RUN cycle. req is ignored in INIT; no ack is produced there.
- Arbitration in RUN, sampled in cycle t:
  - Eligible = req & ~ack. A requester acked this cycle is masked, so a held request is never issued twice.
  - Winner = first eligible index starting at pointer; search wraps modulo NUM_REQ.
  - In cycle t+1: the s2 command is driven from the winner's fields (chipselect=1, write=wr[i]), ack[i]=1, and the pointer becomes (i+1) mod NUM_REQ.
  - With no eligible request: chipselect=0, write=0, and the pointer is unchanged.
  - At most one command per cycle.
- Throughput:
  - One requester alone gets one op every 2 cycles (because of the ack mask).
  - Two or more contending requesters get one op every cycle in aggregate.
- Read return:
  - A tag (valid, requester index) is piped READ_LATENCY+1 stages from the command cycle C.
  - rd_data is registered from s2_readdata at the end of cycle C+READ_LATENCY.
  - rd_valid[i] and rd_data are presented in cycle C+READ_LATENCY+1.
  - Writes produce no rd_valid. rd_data holds its last value when no read is returning.
- Back-to-back ordering: a read issued the cycle after a write to the same address returns the new data, relying on s2 write-then-read ordering. No bypass logic.
- Requester rules: req may drop without ack (request withdrawn, nothing issued). Changing fields while req=1 and not yet acked is illegal; behaviour is undefined.
- Reset mid-operation: async reset clears all pipeline tags (in-flight reads are lost, no rd_valid). The FSM returns to INIT and the zero-fill restarts from address 0.
- Width rules: address slice i = addr[i*ADDR_W +: ADDR_W], with matching slices for wdata and be. The zero-fill address counter is ADDR_W+1 bits, so the terminal count is detected without overflow.

Test Plan:
- Zero-fill after reset (ADDR_W=2): deassert reset -> 4 consecutive s2 writes to addresses 0,1,2,3 with data 0 and be=F. init_done rises the next cycle. req[0] held during INIT gets no ack.
- Single write then read:
  - req0 write addr=2, data=32'hDEADBEEF, be=F -> ack0 one cycle after req. s2 write to address 2.
  - Then req0 read addr=2 -> rd_valid0 three cycles after the req-sample cycle (READ_LATENCY=1), rd_data=DEADBEEF.
- Round-robin contention: req0 and req1 held continuously, each re-requesting right after its ack -> grants alternate 0,1,0,1, one s2 command per cycle, no requester starved.
- Read tagging: req0 reads addr 1 (content 32'h11111111) and req1 reads addr 3 (content 32'h33333333) back-to-back -> rd_valid0 with 11111111, then next cycle rd_valid1 with 33333333. Never both rd_valid bits in the same cycle.
- Byte enables: addr 0 holds 32'hAABBCCDD; write 32'h00000099 with be=4'b0001, then read -> rd_data=AABBCC99.
- Reset mid-read: reset asserted in the cycle after a read command -> no rd_valid emitted. After reset the zero-fill reruns, and reading the previously written address returns 0.
